// File: rtl/sha256_pkg.sv
// Shared constants, types and helpers for the SHA-256 word packer.
package sha256_pkg;

    localparam int unsigned BLOCK_W         = 512;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned SIZE_W          = 64;
    localparam int unsigned WORDS_PER_BLOCK = 16;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [WORD_W-1:0]  word_t;

    typedef enum logic [1:0] {
        SCHEME_SHA256 = 2'd0
    } scheme_e;

    // Keeps the leading (big-endian) bytes of a word; 0 encodes a full word.
    function automatic word_t byte_mask(input logic [1:0] bytes);
        case (bytes)
            2'd1:    byte_mask = 32'hFF00_0000;
            2'd2:    byte_mask = 32'hFFFF_0000;
            2'd3:    byte_mask = 32'hFFFF_FF00;
            default: byte_mask = '1;
        endcase
    endfunction

endpackage

// File: rtl/sha256_word_packer_if.sv
// Word-in, block-out and cfg stream signals of the SHA-256 word packer.
interface sha256_word_packer_if;
    import sha256_pkg::*;

    word_t             data_in;
    logic [1:0]        data_in_bytes;
    logic              data_in_last;
    logic              data_in_valid;
    logic              data_in_ready;

    block_t            data_out;
    logic              data_out_last;
    logic              data_out_valid;
    logic              data_out_ready;

    logic [SIZE_W-1:0] cfg_size;
    logic [1:0]        cfg_scheme;
    logic              cfg_last;
    logic              cfg_valid;
    logic              cfg_ready;

    // Environment side: word source and block/cfg sink.
    modport master (
        output data_in, data_in_bytes, data_in_last, data_in_valid,
        input  data_in_ready,
        input  data_out, data_out_last, data_out_valid,
        output data_out_ready,
        input  cfg_size, cfg_scheme, cfg_last, cfg_valid,
        output cfg_ready
    );

    // Packer side.
    modport slave (
        input  data_in, data_in_bytes, data_in_last, data_in_valid,
        output data_in_ready,
        output data_out, data_out_last, data_out_valid,
        input  data_out_ready,
        output cfg_size, cfg_scheme, cfg_last, cfg_valid,
        input  cfg_ready
    );

endinterface

// File: rtl/sha256_word_packer.sv
// Packs a 32-bit big-endian word stream into zero-filled 512-bit blocks and
// emits the message bit length as a cfg token once per message.
module sha256_word_packer #(
    parameter logic [1:0]  SCHEME          = 2'd0,
    parameter int unsigned WORDS_PER_BLOCK = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync_rst,
    sha256_word_packer_if.slave  bus
);
    import sha256_pkg::*;

    localparam int unsigned      IDX_W    = $clog2(WORDS_PER_BLOCK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

    logic [IDX_W-1:0]  word_idx;
    logic [60:0]       byte_cnt;
    logic [60:0]       byte_cnt_next;
    block_t            asm;
    logic              asm_complete;
    logic              asm_last;
    logic [SIZE_W-1:0] size_pending;
    logic [2:0]        word_bytes;
    word_t             word_masked;
    logic              in_fire;
    logic              xfer;

    always_comb begin
        word_bytes  = 3'd4;
        word_masked = bus.data_in;
        if (bus.data_in_last) begin
            word_bytes  = (bus.data_in_bytes == 2'd0) ? 3'd4 : {1'b0, bus.data_in_bytes};
            word_masked = bus.data_in & byte_mask(bus.data_in_bytes);
        end
    end

    assign byte_cnt_next     = byte_cnt + 61'(word_bytes);
    assign bus.data_in_ready = en && !asm_complete;
    assign in_fire           = bus.data_in_valid && bus.data_in_ready;
    // A last block needs both output slots free so data and cfg go out together.
    assign xfer = en && asm_complete
                  && (!bus.data_out_valid || bus.data_out_ready)
                  && (!asm_last || !bus.cfg_valid || bus.cfg_ready);

    assign bus.cfg_scheme = SCHEME;
    assign bus.cfg_last   = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx           <= '0;
            byte_cnt           <= '0;
            asm                <= '0;
            asm_complete       <= 1'b0;
            asm_last           <= 1'b0;
            size_pending       <= '0;
            bus.data_out       <= '0;
            bus.data_out_valid <= 1'b0;
            bus.data_out_last  <= 1'b0;
            bus.cfg_size       <= '0;
            bus.cfg_valid      <= 1'b0;
        end else if (en) begin
            if (sync_rst) begin
                word_idx           <= '0;
                byte_cnt           <= '0;
                asm                <= '0;
                asm_complete       <= 1'b0;
                asm_last           <= 1'b0;
                size_pending       <= '0;
                bus.data_out       <= '0;
                bus.data_out_valid <= 1'b0;
                bus.data_out_last  <= 1'b0;
                bus.cfg_size       <= '0;
                bus.cfg_valid      <= 1'b0;
            end else begin
                if (bus.data_out_ready) bus.data_out_valid <= 1'b0;
                if (bus.cfg_ready)      bus.cfg_valid      <= 1'b0;

                if (in_fire) begin
                    for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++) begin
                        if (word_idx == IDX_W'(w))
                            asm[BLOCK_W-1-WORD_W*w -: WORD_W] <= word_masked;
                    end
                    byte_cnt <= byte_cnt_next;
                    if (word_idx == LAST_IDX || bus.data_in_last) begin
                        asm_complete <= 1'b1;
                        asm_last     <= bus.data_in_last;
                        if (bus.data_in_last) size_pending <= {byte_cnt_next, 3'b000};
                    end else begin
                        word_idx <= word_idx + 1'b1;
                    end
                end

                // in_fire and xfer are exclusive: input is only taken while asm is open.
                if (xfer) begin
                    bus.data_out       <= asm;
                    bus.data_out_valid <= 1'b1;
                    bus.data_out_last  <= asm_last;
                    if (asm_last) begin
                        bus.cfg_size  <= size_pending;
                        bus.cfg_valid <= 1'b1;
                        byte_cnt      <= '0;
                    end
                    asm          <= '0;
                    word_idx     <= '0;
                    asm_complete <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_word_packer.sv
// Randomised scenario bench for sha256_word_packer with a byte-stream reference model.
module tb_sha256_word_packer;
    import sha256_pkg::*;

    typedef struct packed {
        logic   last;
        block_t data;
    } blk_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic sync_rst;

    sha256_word_packer_if bus();

    sha256_word_packer #(.SCHEME(2'd0), .WORDS_PER_BLOCK(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync_rst (sync_rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    blk_t        obs_blk[$];
    blk_t        exp_blk[$];
    logic [63:0] obs_cfg[$];
    logic [63:0] exp_cfg[$];
    word_t       msg[$];
    logic [1:0]  msg_bytes;
    int unsigned dor_mode = 0;   // 0 ready high, 1 ready low, 2 random
    int unsigned cfr_mode = 0;
    bit          en_rand  = 1'b0;
    bit          gap_rand = 1'b0;

    always @(posedge clk) begin
        #1;
        bus.data_out_ready = (dor_mode == 0) ? 1'b1 : (dor_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.cfg_ready      = (cfr_mode == 0) ? 1'b1 : (cfr_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        if (en_rand) en = ($urandom_range(0, 3) != 0);
    end

    // Records every output transfer that the next rising edge will complete.
    always @(negedge clk) begin
        if (rst === 1'b0 && en && !sync_rst) begin
            if (bus.data_out_valid && bus.data_out_ready)
                obs_blk.push_back({bus.data_out_last, bus.data_out});
            if (bus.cfg_valid && bus.cfg_ready)
                obs_cfg.push_back(bus.cfg_size);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: the message as a byte stream, each word occupying 4 byte slots,
    // invalid tail bytes zero, cut into 64-byte blocks with zero fill.
    task automatic model_push();
        byte unsigned bq[$];
        int unsigned  n;
        int unsigned  eff;
        int unsigned  nblk;
        word_t        w;
        blk_t         e;
        n    = msg.size();
        eff  = (msg_bytes == 2'd0) ? 4 : int'(msg_bytes);
        nblk = (n + 15) / 16;
        for (int i = 0; i < int'(n); i++) begin
            w = msg[i];
            for (int b = 0; b < 4; b++)
                bq.push_back((i == int'(n) - 1 && b >= int'(eff)) ? 8'h00 : w[31-8*b -: 8]);
        end
        while (bq.size() < nblk * 64) bq.push_back(8'h00);
        for (int k = 0; k < int'(nblk); k++) begin
            e.data = '0;
            for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = bq[k*64+j];
            e.last = (k == int'(nblk) - 1);
            exp_blk.push_back(e);
        end
        exp_cfg.push_back(64'(8 * (4 * (n - 1) + eff)));
    endtask

    task automatic send_word(input word_t d, input logic [1:0] nb, input logic lst);
        int t;
        t = 0;
        bus.data_in       = d;
        bus.data_in_bytes = nb;
        bus.data_in_last  = lst;
        bus.data_in_valid = 1'b1;
        @(negedge clk);
        while (!bus.data_in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            checks++;
            errors++;
            $display("FAIL in_accept_timeout word=%h waited %0d cycles, required < 2000", d, t);
        end
        @(posedge clk);
        #1;
        bus.data_in_valid = 1'b0;
    endtask

    task automatic send_msg();
        foreach (msg[i]) begin
            send_word(msg[i], msg_bytes, i == msg.size() - 1);
            if (gap_rand) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((obs_blk.size() < exp_blk.size() || obs_cfg.size() < exp_cfg.size()) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        obs_blk.delete(); exp_blk.delete(); obs_cfg.delete(); exp_cfg.delete();
    endtask

    task automatic test_reset();
        checks++;
        if (bus.data_out_valid !== 1'b0 || bus.cfg_valid !== 1'b0 || bus.data_in_ready !== 1'b1
            || bus.data_out !== '0 || bus.cfg_size !== 64'd0 || bus.data_out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_state dov=%b cv=%b rdy=%b last=%b size=%0d, required 0 0 1 0 0",
                     bus.data_out_valid, bus.cfg_valid, bus.data_in_ready, bus.data_out_last, bus.cfg_size);
        end
        dor_mode = 1; cfr_mode = 1;
        send_word(32'h1234_5678, 2'd0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (bus.data_out_valid !== 1'b1 || bus.cfg_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pending dov=%b cv=%b, required 1 1", bus.data_out_valid, bus.cfg_valid);
        end
        bus.data_in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.data_out_valid !== 1'b0 || bus.cfg_valid !== 1'b0 || bus.cfg_size !== 64'd0) begin
            errors++;
            $display("FAIL async_reset dov=%b cv=%b size=%0d, required 0 0 0",
                     bus.data_out_valid, bus.cfg_valid, bus.cfg_size);
        end
        bus.data_in_valid = 1'b0;
        dor_mode = 0; cfr_mode = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.data_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b, required 1", bus.data_in_ready);
        end
        @(posedge clk); #1;
        clear_queues();
    endtask

    task automatic test_single_word();
        block_t want;
        want = '0;
        want[511:480] = 32'h6162_6300;
        bus.data_in = 32'h6162_6364; bus.data_in_bytes = 2'd3;
        bus.data_in_last = 1'b1; bus.data_in_valid = 1'b1;
        @(posedge clk); #1;
        bus.data_in_valid = 1'b0;
        checks++;
        if (bus.data_out_valid !== 1'b0 || bus.data_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_n dov=%b rdy=%b, required 0 0", bus.data_out_valid, bus.data_in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.data_out_valid !== 1'b1 || bus.cfg_valid !== 1'b1 || bus.data_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_latency_n1 dov=%b cv=%b rdy=%b, required 1 1 1",
                     bus.data_out_valid, bus.cfg_valid, bus.data_in_ready);
        end
        checks++;
        if (bus.data_out !== want || bus.data_out_last !== 1'b1) begin
            errors++;
            $display("FAIL single_data got %h last=%b, required %h last=1", bus.data_out, bus.data_out_last, want);
        end
        checks++;
        if (bus.cfg_size !== 64'd24 || bus.cfg_scheme !== 2'd0 || bus.cfg_last !== 1'b1) begin
            errors++;
            $display("FAIL single_cfg size=%0d scheme=%0d last=%b, required 24 0 1",
                     bus.cfg_size, bus.cfg_scheme, bus.cfg_last);
        end
        wait_drain();
        clear_queues();
    endtask

    task automatic test_block_boundary();
        clear_queues();
        msg.delete();
        for (int i = 0; i < 16; i++) msg.push_back(32'(i));
        msg.push_back(32'hAABB_CCDD);
        msg_bytes = 2'd0;
        model_push();
        send_msg();
        wait_drain();
        checks++;
        if (obs_blk.size() != exp_blk.size() || obs_cfg.size() != 1 || obs_cfg[0] !== 64'd544) begin
            errors++;
            $display("FAIL boundary_counts blocks %0d cfgs %0d size %0d, required %0d 1 544",
                     obs_blk.size(), obs_cfg.size(), (obs_cfg.size() > 0) ? obs_cfg[0] : 64'd0, exp_blk.size());
        end else foreach (exp_blk[i]) begin
            checks++;
            if (obs_blk[i] !== exp_blk[i]) begin
                errors++;
                $display("FAIL boundary_blk[%0d] got %h required %h", i, obs_blk[i], exp_blk[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_queues();
        msg.delete();
        for (int i = 0; i < 32; i++) msg.push_back($urandom);
        msg_bytes = 2'($urandom_range(0, 3));
        model_push();
        dor_mode = 1;
        send_msg();
        repeat (6) begin @(posedge clk); #1; end
        checks++;
        if (bus.data_in_ready !== 1'b0 || bus.data_out_valid !== 1'b1 || obs_blk.size() != 0
            || bus.data_out !== exp_blk[0].data) begin
            errors++;
            $display("FAIL bp_stall rdy=%b dov=%b obs=%0d head_ok=%b, required 0 1 0 1",
                     bus.data_in_ready, bus.data_out_valid, obs_blk.size(), bus.data_out === exp_blk[0].data);
        end
        dor_mode = 0;
        wait_drain();
        checks++;
        if (obs_blk.size() != exp_blk.size() || obs_cfg.size() != exp_cfg.size()) begin
            errors++;
            $display("FAIL bp_counts blocks %0d cfgs %0d, required %0d %0d",
                     obs_blk.size(), obs_cfg.size(), exp_blk.size(), exp_cfg.size());
        end else begin
            foreach (exp_blk[i]) begin
                checks++;
                if (obs_blk[i] !== exp_blk[i]) begin
                    errors++;
                    $display("FAIL bp_blk[%0d] got %h required %h", i, obs_blk[i], exp_blk[i]);
                end
            end
            checks++;
            if (obs_cfg[0] !== exp_cfg[0]) begin
                errors++;
                $display("FAIL bp_cfg got %0d required %0d", obs_cfg[0], exp_cfg[0]);
            end
        end
    endtask

    task automatic test_cfg_stall();
        clear_queues();
        cfr_mode = 1;
        msg.delete(); msg.push_back($urandom); msg_bytes = 2'd1;
        model_push(); send_msg();
        msg.delete(); msg.push_back($urandom); msg_bytes = 2'd0;
        model_push(); send_msg();
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (bus.cfg_valid !== 1'b1 || bus.cfg_size !== 64'd8 || obs_blk.size() != 1
            || bus.data_out_valid !== 1'b0 || bus.data_in_ready !== 1'b0 || obs_cfg.size() != 0) begin
            errors++;
            $display("FAIL cfg_stall cv=%b size=%0d blocks=%0d dov=%b rdy=%b cfgs=%0d, required 1 8 1 0 0 0",
                     bus.cfg_valid, bus.cfg_size, obs_blk.size(), bus.data_out_valid, bus.data_in_ready, obs_cfg.size());
        end
        cfr_mode = 0;
        wait_drain();
        checks++;
        if (obs_blk.size() != 2 || obs_cfg.size() != 2) begin
            errors++;
            $display("FAIL cfgst_counts blocks %0d cfgs %0d, required 2 2", obs_blk.size(), obs_cfg.size());
        end else begin
            foreach (exp_blk[i]) begin
                checks++;
                if (obs_blk[i] !== exp_blk[i] || obs_cfg[i] !== exp_cfg[i]) begin
                    errors++;
                    $display("FAIL cfgst[%0d] size got %0d required %0d, data %h required %h",
                             i, obs_cfg[i], exp_cfg[i], obs_blk[i], exp_blk[i]);
                end
            end
        end
    endtask

    task automatic test_sync_rst();
        clear_queues();
        for (int i = 0; i < 5; i++) send_word($urandom, 2'd0, 1'b0);
        sync_rst = 1'b1;
        bus.data_in = 32'hDEAD_BEEF; bus.data_in_last = 1'b1; bus.data_in_valid = 1'b1;
        @(posedge clk); #1;
        sync_rst = 1'b0;
        bus.data_in_valid = 1'b0;
        msg.delete(); msg.push_back($urandom); msg_bytes = 2'd2;
        model_push(); send_msg();
        wait_drain();
        checks++;
        if (obs_blk.size() != 1 || obs_cfg.size() != 1) begin
            errors++;
            $display("FAIL srst_counts blocks %0d cfgs %0d, required 1 1", obs_blk.size(), obs_cfg.size());
        end else begin
            checks++;
            if (obs_blk[0] !== exp_blk[0] || obs_cfg[0] !== 64'd16) begin
                errors++;
                $display("FAIL srst_out size %0d required 16, data %h required %h", obs_cfg[0], obs_blk[0], exp_blk[0]);
            end
        end
    endtask

    task automatic test_enable();
        clear_queues();
        dor_mode = 1; cfr_mode = 1;
        msg.delete(); msg.push_back($urandom); msg_bytes = 2'd3;
        model_push(); send_msg();
        repeat (2) begin @(posedge clk); #1; end
        en = 1'b0;
        dor_mode = 0; cfr_mode = 0;
        bus.data_in = $urandom; bus.data_in_last = 1'b0; bus.data_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            checks++;
            if (bus.data_in_ready !== 1'b0 || bus.data_out_valid !== 1'b1 || bus.cfg_valid !== 1'b1
                || obs_blk.size() != 0 || bus.data_out !== exp_blk[0].data) begin
                errors++;
                $display("FAIL en_hold[%0d] rdy=%b dov=%b cv=%b obs=%0d, required 0 1 1 0",
                         i, bus.data_in_ready, bus.data_out_valid, bus.cfg_valid, obs_blk.size());
            end
        end
        bus.data_in_valid = 1'b0;
        en = 1'b1;
        wait_drain();
        checks++;
        if (obs_blk.size() != 1 || obs_cfg.size() != 1 || obs_blk[0] !== exp_blk[0] || obs_cfg[0] !== exp_cfg[0]) begin
            errors++;
            $display("FAIL en_release blocks %0d cfgs %0d, required 1 1 with model contents",
                     obs_blk.size(), obs_cfg.size());
        end
    endtask

    task automatic test_random();
        int lens[6];
        clear_queues();
        lens = '{16, 32, 1, 0, 0, 0};
        for (int k = 3; k < 6; k++) lens[k] = $urandom_range(1, 40);
        dor_mode = 2; cfr_mode = 2; en_rand = 1'b1; gap_rand = 1'b1;
        for (int k = 0; k < 6; k++) begin
            msg.delete();
            for (int i = 0; i < lens[k]; i++) msg.push_back($urandom);
            msg_bytes = 2'($urandom_range(0, 3));
            model_push();
            send_msg();
        end
        wait_drain();
        en_rand = 1'b0; gap_rand = 1'b0;
        @(posedge clk); #2;
        en = 1'b1; dor_mode = 0; cfr_mode = 0;
        wait_drain();
        checks++;
        if (obs_blk.size() != exp_blk.size() || obs_cfg.size() != exp_cfg.size()) begin
            errors++;
            $display("FAIL rand_counts blocks %0d cfgs %0d, required %0d %0d",
                     obs_blk.size(), obs_cfg.size(), exp_blk.size(), exp_cfg.size());
        end else begin
            foreach (exp_blk[i]) begin
                checks++;
                if (obs_blk[i] !== exp_blk[i]) begin
                    errors++;
                    $display("FAIL rand_blk[%0d] got %h required %h", i, obs_blk[i], exp_blk[i]);
                end
            end
            foreach (exp_cfg[i]) begin
                checks++;
                if (obs_cfg[i] !== exp_cfg[i]) begin
                    errors++;
                    $display("FAIL rand_cfg[%0d] got %0d required %0d", i, obs_cfg[i], exp_cfg[i]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; sync_rst = 1'b0;
        bus.data_in = '0; bus.data_in_bytes = 2'd0; bus.data_in_last = 1'b0; bus.data_in_valid = 1'b0;
        bus.data_out_ready = 1'b1; bus.cfg_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_single_word();
        test_block_boundary();
        test_backpressure();
        test_cfg_stall();
        test_sync_rst();
        test_enable();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
